// File: rtl/rca_pkg.sv
// Shared definitions for the chunked ripple-carry adder: FSM state encoding
// and the default operand/chunk widths.
package rca_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;

endpackage

// File: rtl/rca_chunk.sv
// Combinational W-bit ripple-carry adder built from per-bit full-adder cells.
module rca_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[W];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: processes one CHUNK-bit slice per clock through
// a single rca_chunk instance, presenting the result with a valid/ready handoff.
module seq_chunk_adder
  import rca_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output state_t           state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid, once raised, holds with its payload until that edge.

  localparam int NCHUNK = (CHUNK > 0) ? WIDTH / CHUNK : 1;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

  if (CHUNK < 1) begin : g_bad_chunk
    $error("seq_chunk_adder: CHUNK must be at least 1");
  end else if (WIDTH % CHUNK != 0) begin : g_bad_width
    $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
  end

  state_t            state, state_next;
  logic [WIDTH-1:0]  a_q, b_q, sum_q;
  logic              carry_q, cout_q, ovf_q;
  logic [IDXW-1:0]   idx;
  logic [CHUNK-1:0]  a_chunk, b_chunk, chunk_sum;
  logic              chunk_cout;
  logic              last;

  assign a_chunk = a_q[int'(idx)*CHUNK +: CHUNK];
  assign b_chunk = b_q[int'(idx)*CHUNK +: CHUNK];
  assign last    = (idx == LAST);

  rca_chunk #(.W(CHUNK)) u_chunk (
    .a    (a_chunk),
    .b    (b_chunk),
    .cin  (carry_q),
    .sum  (chunk_sum),
    .cout (chunk_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx     <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          // Subtraction is A + ~B + 1, so the operand is inverted once here.
          a_q     <= a;
          b_q     <= sub ? ~b : b;
          carry_q <= sub ? 1'b1 : cin;
          idx     <= '0;
          sum_q   <= '0;
          cout_q  <= 1'b0;
          ovf_q   <= 1'b0;
        end
        RUN: begin
          sum_q[int'(idx)*CHUNK +: CHUNK] <= chunk_sum;
          carry_q <= chunk_cout;
          idx     <= last ? '0 : idx + 1'b1;
          if (last) begin
            cout_q <= chunk_cout;
            ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                      (chunk_sum[CHUNK-1] != a_q[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder: 32/8 instance for the main vectors,
// stall and reset sequences; 4/4 instance for the single-chunk case.
module tb_seq_chunk_adder;
  import rca_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 32-bit / 8-bit chunk instance
  logic        in_valid = 0, out_ready = 0, cin = 0, sub = 0;
  logic [31:0] a = '0, b = '0;
  logic        in_ready, out_valid, cout, ovf;
  logic [31:0] sum;
  state_t      state_dbg;

  seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf),
    .state_dbg(state_dbg)
  );

  // 4-bit single-chunk instance
  logic       in_valid4 = 0, out_ready4 = 0, cin4 = 0, sub4 = 0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       in_ready4, out_valid4, cout4, ovf4;
  logic [3:0] sum4;
  state_t     state_dbg4;

  seq_chunk_adder #(.WIDTH(4), .CHUNK(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .sub(sub4), .out_valid(out_valid4),
    .out_ready(out_ready4), .sum(sum4), .cout(cout4), .ovf(ovf4),
    .state_dbg(state_dbg4)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [33:0] exp_q[$];   // {cout, ovf, sum}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic run32(input logic [31:0] ta, input logic [31:0] tb_v,
                       input logic tcin, input logic tsub, input string name);
    int lat;
    bit got;
    logic [33:0] exp;
    @(negedge clk);
    check({name, " in_ready"}, 64'(in_ready), 64'd1);
    a = ta; b = tb_v; cin = tcin; sub = tsub; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clk);
      #1 lat++;
      if (out_valid) got = 1;
    end
    check({name, " latency"}, 64'(lat), 64'd4);
    exp = exp_q.pop_front();
    check({name, " sum"},  64'(sum),  64'(exp[31:0]));
    check({name, " cout"}, 64'(cout), 64'(exp[33]));
    check({name, " ovf"},  64'(ovf),  64'(exp[32]));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({name, " release"}, 64'(out_valid), 64'd0);
  endtask

  task automatic run4(input logic [3:0] ta, input logic [3:0] tb_v, input logic tcin,
                      input logic tsub, input logic [3:0] esum, input logic ecout,
                      input logic eovf, input string name);
    int lat;
    bit got;
    @(negedge clk);
    a4 = ta; b4 = tb_v; cin4 = tcin; sub4 = tsub; in_valid4 = 1'b1;
    @(posedge clk);
    #1 in_valid4 = 1'b0;
    lat = 0;
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(posedge clk);
      #1 lat++;
      if (out_valid4) got = 1;
    end
    check({name, " latency"}, 64'(lat),   64'd1);
    check({name, " sum"},     64'(sum4),  64'(esum));
    check({name, " cout"},    64'(cout4), 64'(ecout));
    check({name, " ovf"},     64'(ovf4),  64'(eovf));
    @(negedge clk);
    out_ready4 = 1'b1;
    @(posedge clk);
    #1 out_ready4 = 1'b0;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
    string       name;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int seen;
    vecs[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "add_ones_plus1"};
    vecs[1]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_5_7"};
    vecs[2]  = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0, "sub_7_5"};
    vecs[3]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "add_pos_ovf"};
    vecs[4]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "sub_neg_ovf"};
    vecs[5]  = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 32'hACF1_3569, 1'b0, 1'b0, "add_mixed_cin"};
    vecs[6]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0, "add_zero_cin"};
    vecs[7]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, "sub_zero"};
    vecs[8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, "add_all_ones"};
    vecs[9]  = '{32'h0000_0010, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_000D, 1'b1, 1'b0, "sub_cin_ignored"};
    vecs[10] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, "add_neg_ovf"};
    vecs[11] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, "add_chunk_carry"};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst sum",       64'(sum),       64'd0);
    check("rst cout",      64'(cout),      64'd0);
    check("rst ovf",       64'(ovf),       64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst in_ready",  64'(in_ready),  64'd1);
    check("rst state",     64'(state_dbg), 64'(IDLE));
    check("rst in_ready4", 64'(in_ready4), 64'd1);

    // table-driven main function
    foreach (vecs[i]) begin
      exp_q.push_back({vecs[i].exp_cout, vecs[i].exp_ovf, vecs[i].exp_sum});
      run32(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].name);
    end

    // back-pressure: result held, new requests ignored
    @(negedge clk);
    a = 32'h1111_1111; b = 32'h2222_2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && !out_valid; k++) begin
      @(posedge clk);
      #1 seen++;
    end
    check("stall latency", 64'(seen), 64'd4);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; sub = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("stall sum",       64'(sum),       64'h3333_3333);
      check("stall cout",      64'(cout),      64'd0);
      check("stall ovf",       64'(ovf),       64'd0);
      check("stall out_valid", 64'(out_valid), 64'd1);
      check("stall in_ready",  64'(in_ready),  64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("handoff in_ready",  64'(in_ready),  64'd1);
    check("handoff out_valid", 64'(out_valid), 64'd0);
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1 check("handoff no accept", 64'(state_dbg), 64'(IDLE));

    // reset in the middle of RUN
    @(negedge clk);
    a = 32'h0101_0101; b = 32'h0101_0101; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("abort in RUN", 64'(state_dbg), 64'(RUN));
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort async state", 64'(state_dbg), 64'(IDLE));
    check("abort async sum",   64'(sum),       64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort in_ready",  64'(in_ready),  64'd1);
    check("abort out_valid", 64'(out_valid), 64'd0);
    check("abort sum",       64'(sum),       64'd0);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1 if (out_valid) seen++;
    end
    check("abort no result", 64'(seen), 64'd0);
    exp_q.push_back({1'b0, 1'b0, 32'h0000_0003});
    run32(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, "after_abort");

    // single-chunk configuration
    run4(4'h9, 4'h8, 1'b1, 1'b0, 4'h2, 1'b1, 1'b1, "w4_add_9_8_c");
    run4(4'h7, 4'h1, 1'b0, 1'b0, 4'h8, 1'b0, 1'b1, "w4_add_7_1");
    run4(4'h3, 4'h5, 1'b0, 1'b1, 4'hE, 1'b0, 1'b0, "w4_sub_3_5");

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_chunk_adder.md
SEQ_CHUNK_ADDER -- requirements
Module: seq_chunk_adder

Interface
REQ-001 Parameter WIDTH, default 32, total operand width in bits.
REQ-002 Parameter CHUNK, default 8, bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK; NCHUNK = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-005 in_valid  input  1  operand request valid.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 a  input  WIDTH  operand A, unsigned/two's complement.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in, used in add mode only.
REQ-010 sub  input  1  0 = add (A+B+cin), 1 = subtract (A-B, cin ignored).
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  carry-out of MSB; in sub mode 1 = no borrow (A >= B unsigned).
REQ-015 ovf  output  1  signed two's-complement overflow.

Function
REQ-016 States SHALL be IDLE, RUN, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-017 IDLE: on in_valid=1, SHALL capture a, b (inverted when sub=1), initial carry (cin in add, 1 in sub), clear chunk index, go to RUN; inputs ignored at all other times.
REQ-018 RUN: each cycle SHALL add chunk[idx] of A and B plus stored carry, write CHUNK result bits into sum at chunk idx, store chunk carry-out, increment idx.
REQ-019 After chunk NCHUNK-1 is processed, SHALL go to DONE with cout = final carry and ovf = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]), where B' is the post-inversion operand.
REQ-020 Latency: out_valid SHALL rise exactly NCHUNK cycles after the accepting edge.
REQ-021 DONE: sum, cout, ovf SHALL hold stable while out_ready=0; on out_ready=1 SHALL return to IDLE next edge; no accept in the same cycle as result handoff.
REQ-022 Result SHALL equal (A + B + cin) mod 2^WIDTH (add) or (A - B) mod 2^WIDTH (sub) for all operands, including all-ones and zero.
REQ-023 Chunk index counter width SHALL be clog2(NCHUNK), minimum 1 bit; CHUNK == WIDTH SHALL give NCHUNK = 1 and be legal.
REQ-024 sum, cout, ovf SHALL be undefined-free (held from last operation or zero) outside DONE; checkers sample only when out_valid=1.

Reset
REQ-025 rst_n low SHALL asynchronously force state IDLE, index 0, carry 0, sum 0, cout 0, ovf 0, out_valid 0; in_ready 1 after release.
REQ-026 Reset asserted in RUN or DONE SHALL abort the operation with no result ever presented.

Structure
REQ-027 Package rca_pkg SHALL hold the state encoding (IDLE, RUN, DONE) and the default WIDTH/CHUNK constants.
REQ-028 One sub-module rca_chunk SHALL implement the combinational CHUNK-bit ripple-carry adder (a, b, cin -> sum, cout) built from per-bit full-adder cells; seq_chunk_adder instantiates it once.
REQ-029 Compile-time check SHALL reject WIDTH % CHUNK != 0 or CHUNK < 1.

Verification (WIDTH=32, CHUNK=8 unless stated)
REQ-030 add 0xFFFFFFFF + 0x00000001, cin=0 -> sum 0x00000000, cout 1, ovf 0, out_valid 4 cycles after accept.
REQ-031 sub 0x00000005 - 0x00000007 -> sum 0xFFFFFFFE, cout 0, ovf 0; sub 7-5 -> sum 0x00000002, cout 1.
REQ-032 add 0x7FFFFFFF + 0x00000001, cin=0 -> sum 0x80000000, cout 0, ovf 1; sub 0x80000000 - 1 -> 0x7FFFFFFF, ovf 1.
REQ-033 out_ready held 0 for 10 cycles in DONE -> outputs stable, in_ready 0, concurrent in_valid with new operands ignored; out_ready=1 -> IDLE next edge.
REQ-034 rst_n pulsed low after 2 RUN cycles -> out_valid 0, sum 0, in_ready 1 immediately after release; next operation 0x1+0x2 -> 0x3 correct.
REQ-035 WIDTH=4, CHUNK=4: add 4'h9 + 4'h8, cin=1 -> sum 4'h2, cout 1, ovf 1, out_valid 1 cycle after accept.
